pid_gain_sequencer: RTL and testbench
=====================================

Name: pid_gain_sequencer

Overview:
- Single-clock controller between the I2C register-write front end and the PID datapath.
- Captures gain writes (Kp/Ki/Kd) into shadow registers.
- Commits all pending shadows atomically at the next sample tick, then launches one PID computation with a start/done handshake.
- Guarantees the datapath never sees a gain change mid-computation, and reports overruns and timeouts.

Parameters:
- GAIN_W, 6, width of each gain value
- KP_ADDR, 8'h00, register address of Kp
- KI_ADDR, 8'h01, register address of Ki
- KD_ADDR, 8'h02, register address of Kd
- KP_RST, 6'd0, reset value of Kp (active and shadow)
- KI_RST, 6'd0, reset value of Ki
- KD_RST, 6'd0, reset value of Kd
- TIMEOUT, 64, max clk cycles from pid_start to pid_done

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  enables tick processing; gain writes are accepted regardless
- wr_valid  in  1  one-cycle write strobe, already synchronised to clk
- wr_addr  in  8  target register address
- wr_data  in  GAIN_W  gain value
- wr_ack  out  1  one-cycle pulse: write accepted
- wr_nack  out  1  one-cycle pulse: address invalid
- sample_tick  in  1  one-cycle sample-period strobe
- pid_start  out  1  one-cycle pulse to the datapath
- pid_done  in  1  one-cycle completion pulse from the datapath
- kp, ki, kd  out  GAIN_W each  active gains to the datapath
- busy  out  1  high in COMMIT or RUN
- overrun  out  1  sticky: tick arrived while busy
- timeout  out  1  sticky: pid_done not seen within TIMEOUT
- err_cnt  out  4  saturating count of NACKed writes
- clr_flags  in  1  synchronous clear of overrun, timeout and err_cnt
- state  out  2  current FSM state, for debug

Behaviour:
- Reset (asynchronous):
  - kp/ki/kd and the shadows take their *_RST values.
  - Pending mask is 0.
  - State is IDLE.
  - wr_ack, wr_nack, pid_start, busy, overrun, timeout and err_cnt are 0.
- Write path (independent of the FSM):
  - On a wr_valid cycle with wr_addr equal to KP_ADDR, KI_ADDR or KD_ADDR: the matching shadow gets wr_data, its pending bit is set, and wr_ack pulses on the next cycle.
  - Any other address: no state change, wr_nack pulses on the next cycle, err_cnt increments and saturates at 15.
  - A repeat write before commit overwrites the shadow; last write wins.
- FSM states: IDLE=0, COMMIT=1, RUN=2, DRAIN=3.
- IDLE:
  - If sample_tick and ena: go to COMMIT.
  - A tick with ena low is ignored and does not set overrun.
- COMMIT (exactly 1 cycle):
  - For each set pending bit, the active gain gets the shadow value and the bit is cleared.
  - pid_start is asserted in the same cycle; go to RUN.
  - Active gains change on the clock edge ending COMMIT, so they are stable from the first RUN cycle.
- RUN:
  - A timeout counter starts at 0 and increments each cycle.
  - pid_done: go to IDLE.
  - Counter reaches TIMEOUT-1 without pid_done: set timeout, go to DRAIN.
- DRAIN:
  - Wait for pid_done or one sample_tick, whichever comes first, then go to IDLE.
  - No pid_start is issued and no gains are committed in DRAIN.
- busy is high in COMMIT and RUN.
- sample_tick in COMMIT, RUN or DRAIN sets overrun and is dropped; it is not queued.
- Write and commit in the same cycle:
  - The commit uses the shadow values and pending bits from before that cycle.
  - The new write lands in the shadow with its pending bit set, to be committed at the next tick.
  - If the write hits a register being committed in that cycle, the old value is committed and the new value stays pending.
- pid_done in IDLE or COMMIT is ignored.
- ena deassert while in RUN or DRAIN: the current operation completes normally; no new tick is accepted.
- clr_flags:
  - Clears the flags in the same edge.
  - If a set event coincides with clr_flags, the set wins.
- Asynchronous reset mid-RUN: returns to IDLE immediately and drops the pending mask. The datapath must also be reset.

Decomposition:
- Shared package (pid_pkg) holds:
  - gain width
  - the register addresses KP/KI/KD (also used by the I2C slave)
  - the FSM state encoding
  - the reset gains
- One natural sub-module, pid_gain_shadow: the three shadow/active register pairs plus the pending mask, with write and commit ports.
- The FSM, timeout counter and flags stay in the top module.

Test Plan:
- Reset, then write addr 8'h01 data 6'd17, then sample_tick -> wr_ack one cycle after the write; ki changes to 17 only after COMMIT; pid_start is one pulse; kp and kd stay 0.
- Write addr 8'h05 -> wr_nack pulses, err_cnt=1, no gain changes. After 16 more bad writes err_cnt=15; clr_flags returns it to 0.
- Write kp=9 in the same cycle COMMIT commits a pending kp=4 -> kp=4 after COMMIT; pending bit stays set; the next tick gives kp=9.
- sample_tick 3 cycles into RUN -> overrun=1; no second pid_start; return to IDLE on pid_done.
- Withhold pid_done with TIMEOUT=8 -> timeout=1 after 8 RUN cycles; state=DRAIN; a late pid_done returns to IDLE; the next tick starts normally.
- Assert rst_n low mid-RUN with pending writes -> immediately IDLE with *_RST gains and the pending mask cleared; busy=0.

Source files
------------

// File: rtl/pid_pkg.sv
// pid_pkg
// Shared definitions for the PID gain sequencer and the I2C register front end:
// the gain width, the register map addresses of Kp/Ki/Kd, the reset gains and
// the sequencer FSM state encoding.
package pid_pkg;

   localparam int PID_GAIN_W = 6;

   localparam logic [7:0] PID_KP_ADDR = 8'h00;
   localparam logic [7:0] PID_KI_ADDR = 8'h01;
   localparam logic [7:0] PID_KD_ADDR = 8'h02;

   localparam logic [PID_GAIN_W-1:0] PID_KP_RST = 6'd0;
   localparam logic [PID_GAIN_W-1:0] PID_KI_RST = 6'd0;
   localparam logic [PID_GAIN_W-1:0] PID_KD_RST = 6'd0;

   // Encoding is visible on the debug state port, so the values are fixed.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COMMIT = 2'd1,
      RUN    = 2'd2,
      DRAIN  = 2'd3
   } pid_state_t;

endpackage

// File: rtl/pid_gain_shadow.sv
// pid_gain_shadow
// Three shadow/active gain register pairs plus the pending mask.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en             write strobe (already qualified by wr_valid)
//   wr_addr, wr_data  target register address and gain value
//   addr_hit          combinational: wr_addr names one of the three gains
//   commit            copy every pending shadow into its active register
//   kp, ki, kd        active gains seen by the datapath
module pid_gain_shadow
   import pid_pkg::*;
#(
   parameter int                GAIN_W  = PID_GAIN_W,
   parameter logic [7:0]        KP_ADDR = PID_KP_ADDR,
   parameter logic [7:0]        KI_ADDR = PID_KI_ADDR,
   parameter logic [7:0]        KD_ADDR = PID_KD_ADDR,
   parameter logic [GAIN_W-1:0] KP_RST  = PID_KP_RST,
   parameter logic [GAIN_W-1:0] KI_RST  = PID_KI_RST,
   parameter logic [GAIN_W-1:0] KD_RST  = PID_KD_RST
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [7:0]        wr_addr,
   input  logic [GAIN_W-1:0] wr_data,
   output logic              addr_hit,
   input  logic              commit,
   output logic [GAIN_W-1:0] kp,
   output logic [GAIN_W-1:0] ki,
   output logic [GAIN_W-1:0] kd
);

   logic              hit_kp;
   logic              hit_ki;
   logic              hit_kd;
   logic [2:0]        pending;
   logic [2:0]        pending_next;
   logic [GAIN_W-1:0] kp_sh;
   logic [GAIN_W-1:0] ki_sh;
   logic [GAIN_W-1:0] kd_sh;

   // Address decode for the three gain registers.
   always_comb begin
      hit_kp   = (wr_addr == KP_ADDR);
      hit_ki   = (wr_addr == KI_ADDR);
      hit_kd   = (wr_addr == KD_ADDR);
      addr_hit = hit_kp | hit_ki | hit_kd;
   end

   // A commit clears the whole mask, but a write in the same cycle re-arms its
   // own bit so that value waits for the following commit.
   always_comb begin
      pending_next = commit ? 3'b000 : pending;
      pending_next = pending_next | ({hit_kd, hit_ki, hit_kp} & {3{wr_en}});
   end

   // Commit reads the shadow values from before this edge, so a write landing
   // on a register being committed leaves the old value active and the new
   // value pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kp      <= KP_RST;
         ki      <= KI_RST;
         kd      <= KD_RST;
         kp_sh   <= KP_RST;
         ki_sh   <= KI_RST;
         kd_sh   <= KD_RST;
         pending <= 3'b000;
      end else begin
         if (commit && pending[0]) kp <= kp_sh;
         if (commit && pending[1]) ki <= ki_sh;
         if (commit && pending[2]) kd <= kd_sh;
         if (wr_en && hit_kp) kp_sh <= wr_data;
         if (wr_en && hit_ki) ki_sh <= wr_data;
         if (wr_en && hit_kd) kd_sh <= wr_data;
         pending <= pending_next;
      end
   end

endmodule

// File: rtl/pid_gain_sequencer.sv
// pid_gain_sequencer
// Sits between the register-write front end and the PID datapath. Gain writes
// go to shadow registers; at each enabled sample tick the pending shadows are
// committed atomically and one PID computation is launched with a start/done
// handshake, so the datapath never sees a gain change mid-computation.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ena                     enables tick processing (writes always accepted)
//   wr_valid/addr/data      register write strobe, address and gain value
//   wr_ack, wr_nack         one-cycle write accepted / address invalid pulses
//   sample_tick             sample-period strobe
//   pid_start, pid_done     datapath launch pulse and completion pulse
//   kp, ki, kd              active gains
//   busy                    high in COMMIT and RUN
//   overrun, timeout        sticky error flags
//   err_cnt                 saturating count of NACKed writes
//   clr_flags               clears overrun, timeout and err_cnt
//   state                   current FSM state
module pid_gain_sequencer
   import pid_pkg::*;
#(
   parameter int                GAIN_W  = PID_GAIN_W,
   parameter logic [7:0]        KP_ADDR = PID_KP_ADDR,
   parameter logic [7:0]        KI_ADDR = PID_KI_ADDR,
   parameter logic [7:0]        KD_ADDR = PID_KD_ADDR,
   parameter logic [GAIN_W-1:0] KP_RST  = PID_KP_RST,
   parameter logic [GAIN_W-1:0] KI_RST  = PID_KI_RST,
   parameter logic [GAIN_W-1:0] KD_RST  = PID_KD_RST,
   parameter int                TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              wr_valid,
   input  logic [7:0]        wr_addr,
   input  logic [GAIN_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              wr_nack,
   input  logic              sample_tick,
   output logic              pid_start,
   input  logic              pid_done,
   output logic [GAIN_W-1:0] kp,
   output logic [GAIN_W-1:0] ki,
   output logic [GAIN_W-1:0] kd,
   output logic              busy,
   output logic              overrun,
   output logic              timeout,
   output logic [3:0]        err_cnt,
   input  logic              clr_flags,
   output logic [1:0]        state
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   pid_state_t       state_q;
   logic [CNT_W-1:0] run_cnt;
   logic             addr_hit;
   logic             commit;

   assign commit = (state_q == COMMIT);
   assign state  = state_q;

   pid_gain_shadow #(
      .GAIN_W  (GAIN_W),
      .KP_ADDR (KP_ADDR),
      .KI_ADDR (KI_ADDR),
      .KD_ADDR (KD_ADDR),
      .KP_RST  (KP_RST),
      .KI_RST  (KI_RST),
      .KD_RST  (KD_RST)
   ) u_shadow (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .addr_hit (addr_hit),
      .commit   (commit),
      .kp       (kp),
      .ki       (ki),
      .kd       (kd)
   );

   // Write responses and the NACK counter run independently of the FSM.
   // When a bad write coincides with clr_flags the count restarts at one,
   // so the new error is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ack  <= 1'b0;
         wr_nack <= 1'b0;
         err_cnt <= 4'd0;
      end else begin
         wr_ack  <= wr_valid & addr_hit;
         wr_nack <= wr_valid & ~addr_hit;
         if (wr_valid && !addr_hit) begin
            if (clr_flags)
               err_cnt <= 4'd1;
            else if (err_cnt != 4'hF)
               err_cnt <= err_cnt + 4'd1;
         end else if (clr_flags) begin
            err_cnt <= 4'd0;
         end
      end
   end

   // Sequencer FSM. pid_start and busy are registered alongside the state so
   // they line up with COMMIT/RUN. The flag set terms come after the clear so
   // a coinciding set event wins. A tick outside IDLE is only recorded as an
   // overrun, except in DRAIN where it also ends the wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pid_start <= 1'b0;
         busy      <= 1'b0;
         run_cnt   <= '0;
         overrun   <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         pid_start <= 1'b0;
         if (clr_flags) begin
            overrun <= 1'b0;
            timeout <= 1'b0;
         end
         if (sample_tick && state_q != IDLE)
            overrun <= 1'b1;
         case (state_q)
            IDLE: begin
               if (sample_tick && ena) begin
                  state_q   <= COMMIT;
                  pid_start <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            COMMIT: begin
               state_q <= RUN;
               run_cnt <= '0;
            end
            RUN: begin
               if (pid_done) begin
                  state_q <= IDLE;
                  busy    <= 1'b0;
               end else if (run_cnt == CNT_LAST) begin
                  state_q <= DRAIN;
                  busy    <= 1'b0;
                  timeout <= 1'b1;
               end else begin
                  run_cnt <= run_cnt + 1'b1;
               end
            end
            DRAIN: begin
               if (pid_done || sample_tick)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pid_gain_sequencer.sv
// tb_pid_gain_sequencer
// Scoreboard bench: expected write responses and expected committed gains are
// queued as stimulus is driven, then popped by a monitor when the DUT answers.
module tb_pid_gain_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [5:0] wr_data;
   logic       wr_ack;
   logic       wr_nack;
   logic       sample_tick;
   logic       pid_start;
   logic       pid_done;
   logic [5:0] kp;
   logic [5:0] ki;
   logic [5:0] kd;
   logic       busy;
   logic       overrun;
   logic       timeout;
   logic [3:0] err_cnt;
   logic       clr_flags;
   logic [1:0] state;

   int errors = 0;
   int checks = 0;
   int starts = 0;
   bit start_pend = 1'b0;

   logic [1:0]  wq[$];
   logic [17:0] gq[$];

   pid_gain_sequencer #(.TIMEOUT(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ack      (wr_ack),
      .wr_nack     (wr_nack),
      .sample_tick (sample_tick),
      .pid_start   (pid_start),
      .pid_done    (pid_done),
      .kp          (kp),
      .ki          (ki),
      .kd          (kd),
      .busy        (busy),
      .overrun     (overrun),
      .timeout     (timeout),
      .err_cnt     (err_cnt),
      .clr_flags   (clr_flags),
      .state       (state)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] addr, input logic [5:0] data);
      wr_valid = 1'b1;
      wr_addr  = addr;
      wr_data  = data;
      wq.push_back((addr <= 8'h02) ? 2'b10 : 2'b01);
      step();
      wr_valid = 1'b0;
   endtask

   task automatic tick();
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
   endtask

   task automatic pulseDone();
      pid_done = 1'b1;
      step();
      pid_done = 1'b0;
   endtask

   task automatic pulseClear();
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
   endtask

   task automatic waitState(input logic [1:0] s, input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (state !== s && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("wait_state", state, s);
   endtask

   // Monitor: pops expectations when the DUT produces a response.
   always @(negedge clk) begin
      if (rst_n) begin
         if (start_pend) begin
            start_pend = 1'b0;
            checkOutput("gain_queue", gq.size() != 0, 1);
            if (gq.size() != 0)
               checkOutput("gains", {kp, ki, kd}, gq.pop_front());
         end
         if (pid_start) begin
            starts++;
            start_pend = 1'b1;
         end
         if (wr_ack || wr_nack) begin
            checkOutput("wr_queue", wq.size() != 0, 1);
            if (wq.size() != 0)
               checkOutput("wr_resp", {wr_ack, wr_nack}, wq.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n = 1'b0; ena = 1'b1; wr_valid = 1'b0; wr_addr = 8'h00; wr_data = 6'd0;
      sample_tick = 1'b0; pid_done = 1'b0; clr_flags = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      checkOutput("rst_gains", {kp, ki, kd}, 18'd0);
      checkOutput("rst_state", state, 2'd0);
      checkOutput("rst_flags", {busy, overrun, timeout, pid_start, wr_ack, wr_nack}, 6'd0);
      checkOutput("rst_errcnt", err_cnt, 4'd0);

      // Ki write, commit on tick
      applyStimulus(8'h01, 6'd17);
      @(negedge clk);
      checkOutput("ki_before_commit", ki, 6'd0);
      gq.push_back({6'd0, 6'd17, 6'd0});
      tick();
      @(negedge clk);
      checkOutput("commit_state", state, 2'd1);
      checkOutput("commit_start", pid_start, 1'b1);
      checkOutput("commit_ki_old", ki, 6'd0);
      @(negedge clk);
      checkOutput("run_state", state, 2'd2);
      checkOutput("run_busy", busy, 1'b1);
      checkOutput("run_start_low", pid_start, 1'b0);
      pulseDone();
      waitState(2'd0, 4);
      checkOutput("idle_busy", busy, 1'b0);

      // Bad writes, saturation, clear
      applyStimulus(8'h05, 6'd33);
      @(negedge clk);
      checkOutput("errcnt_1", err_cnt, 4'd1);
      checkOutput("nack_gains", {kp, ki, kd}, {6'd0, 6'd17, 6'd0});
      for (int i = 0; i < 16; i++) applyStimulus(8'h10 + 8'(i), 6'(i));
      @(negedge clk);
      checkOutput("errcnt_sat", err_cnt, 4'd15);
      pulseClear();
      @(negedge clk);
      checkOutput("errcnt_clr", err_cnt, 4'd0);

      // Tick with ena low is ignored
      ena = 1'b0;
      tick();
      @(negedge clk);
      checkOutput("ena_low_state", state, 2'd0);
      checkOutput("ena_low_overrun", overrun, 1'b0);
      ena = 1'b1;

      // Write during COMMIT to the register being committed
      applyStimulus(8'h00, 6'd4);
      gq.push_back({6'd4, 6'd17, 6'd0});
      tick();
      applyStimulus(8'h00, 6'd9);
      @(negedge clk);
      checkOutput("kp_old_commit", kp, 6'd4);
      pulseDone();
      waitState(2'd0, 4);
      gq.push_back({6'd9, 6'd17, 6'd0});
      tick();
      step();
      pulseDone();
      waitState(2'd0, 4);
      checkOutput("kp_new_commit", kp, 6'd9);

      // Overrun: tick three cycles into RUN
      gq.push_back({6'd9, 6'd17, 6'd0});
      tick();
      step();
      repeat (3) step();
      tick();
      @(negedge clk);
      checkOutput("overrun_set", overrun, 1'b1);
      checkOutput("overrun_state", state, 2'd2);
      checkOutput("overrun_no_start", pid_start, 1'b0);
      pulseDone();
      waitState(2'd0, 4);
      checkOutput("overrun_sticky", overrun, 1'b1);
      pulseClear();
      @(negedge clk);
      checkOutput("overrun_clr", overrun, 1'b0);

      // Timeout after 8 RUN cycles
      gq.push_back({6'd9, 6'd17, 6'd0});
      tick();
      step();
      repeat (7) step();
      @(negedge clk);
      checkOutput("to_last_run", state, 2'd2);
      checkOutput("to_not_yet", timeout, 1'b0);
      @(negedge clk);
      checkOutput("to_drain", state, 2'd3);
      checkOutput("to_set", timeout, 1'b1);
      checkOutput("to_busy", busy, 1'b0);
      pulseDone();
      waitState(2'd0, 4);
      gq.push_back({6'd9, 6'd17, 6'd0});
      tick();
      @(negedge clk);
      checkOutput("after_to_commit", state, 2'd1);
      step();
      pulseDone();
      waitState(2'd0, 4);

      // Reset mid-RUN with pending writes
      gq.push_back({6'd9, 6'd17, 6'd0});
      tick();
      step();
      applyStimulus(8'h02, 6'd5);
      applyStimulus(8'h01, 6'd3);
      step();
      rst_n = 1'b0;
      #2;
      checkOutput("arst_state", state, 2'd0);
      checkOutput("arst_gains", {kp, ki, kd}, 18'd0);
      checkOutput("arst_flags", {busy, timeout, overrun, pid_start}, 4'd0);
      step();
      rst_n = 1'b1;
      gq.push_back({6'd0, 6'd0, 6'd0});
      tick();
      step();
      pulseDone();
      waitState(2'd0, 4);

      repeat (3) step();
      checkOutput("start_count", starts, 8);
      checkOutput("wq_empty", wq.size(), 0);
      checkOutput("gq_empty", gq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
